// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with midpoint sampling, parity and
// stop-bit checks, and a valid/ready output register with error flags.
//
// Ports:
//   clk            rising-edge clock
//   reset_b        asynchronous active-low reset
//   RX_Data_in     serial line, idles high
//   RX_Data_Taken  consumer accepts the word when RX_Data_Valid is high
//   RX_Data_out    last committed word
//   RX_Data_Valid  RX_Data_out holds an unconsumed word
//   Parity_Error   parity mismatch on the word in RX_Data_out
//   Framing_Error  a stop bit sampled low on the word in RX_Data_out
//   Overrun_Error  sticky; frames were dropped while a word was pending
//   RX_Busy        receiver FSM is not idle
module uart_rx_frame #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 RX_Data_in,
  input  logic                 RX_Data_Taken,
  output logic [WORD_SIZE-1:0] RX_Data_out,
  output logic                 RX_Data_Valid,
  output logic                 Parity_Error,
  output logic                 Framing_Error,
  output logic                 Overrun_Error,
  output logic                 RX_Busy
);

  localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(WORD_SIZE + 1);

  localparam logic [TickW-1:0] TickFull = TickW'(CLKS_PER_BIT - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0]  LastData = BitW'(WORD_SIZE - 1);
  localparam logic [BitW-1:0]  LastStop = BitW'(STOP_BITS - 1);
  localparam logic             ParOdd   = (PARITY_ODD != 0);
  localparam logic             ParEn    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StCommit, StBrkWait
  } state_e;

  // Synchroniser, plus a priming chain that marks when the synchroniser holds
  // only real line samples (its reset value of 1 must not count as idle).
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   srx;
  logic                   primed;
  logic                   idle_q;

  assign srx    = sync_q[SYNC_STAGES-1];
  assign primed = prime_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q  <= '1;
      prime_q <= '0;
      idle_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RX_Data_in};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      idle_q  <= primed & srx;
    end
  end

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 last_low_q, last_low_d;
  logic                 commit;
  logic                 tick_done;

  assign tick_done = (tick_q == TickFull);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    last_low_d = last_low_q;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        bit_d  = '0;
        if (idle_q && !srx) begin
          state_d = StStart;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (tick_q == TickHalf) begin
          tick_d  = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = srx ? StIdle : StData;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StData: begin
        if (tick_done) begin
          tick_d  = '0;
          shift_d = {srx, shift_q[WORD_SIZE-1:1]};
          if (bit_q == LastData) begin
            bit_d   = '0;
            state_d = ParEn ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StParity: begin
        if (tick_done) begin
          tick_d  = '0;
          perr_d  = ((^shift_q) ^ srx) != ParOdd;
          state_d = StStop;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StStop: begin
        if (tick_done) begin
          tick_d     = '0;
          last_low_d = !srx;
          if (!srx) begin
            ferr_d = 1'b1;
          end
          if (bit_q == LastStop) begin
            bit_d   = '0;
            state_d = StCommit;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        // A low final stop bit means a break: wait for the line to recover.
        state_d = last_low_q ? StBrkWait : StIdle;
      end
      StBrkWait: begin
        if (srx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      last_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      last_low_q <= last_low_d;
    end
  end

  // Output register and handshake.
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 operr_q, operr_d;
  logic                 oferr_q, oferr_d;
  logic                 ovr_q, ovr_d;
  logic                 xfer;

  assign xfer = valid_q & RX_Data_Taken;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    ovr_d   = ovr_q;
    if (xfer) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      if (!valid_q || RX_Data_Taken) begin
        data_d  = shift_q;
        operr_d = perr_q;
        oferr_d = ferr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign RX_Data_out   = data_q;
  assign RX_Data_Valid = valid_q;
  assign Parity_Error  = operr_q;
  assign Framing_Error = oferr_q;
  assign Overrun_Error = ovr_q;
  assign RX_Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance (dut_n) and an 8E2 instance (dut_p).
// Frames are pushed as expected words into per-instance queues; monitors pop and
// compare on every accepted word.
module tb_uart_rx_frame;

  localparam int unsigned Clks = 16;
  localparam int unsigned Sync = 2;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  logic line_n = 1'b1, taken_n = 1'b1;
  logic line_p = 1'b1, taken_p = 1'b1;

  logic [7:0] data_n, data_p;
  logic valid_n, perr_n, ferr_n, ovr_n, busy_n;
  logic valid_p, perr_p, ferr_p, ovr_p, busy_p;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .WORD_SIZE(8), .CLKS_PER_BIT(Clks), .PARITY_EN(0), .PARITY_ODD(0),
    .STOP_BITS(1), .SYNC_STAGES(Sync)
  ) dut_n (
    .clk(clk), .reset_b(reset_b), .RX_Data_in(line_n), .RX_Data_Taken(taken_n),
    .RX_Data_out(data_n), .RX_Data_Valid(valid_n), .Parity_Error(perr_n),
    .Framing_Error(ferr_n), .Overrun_Error(ovr_n), .RX_Busy(busy_n)
  );

  uart_rx_frame #(
    .WORD_SIZE(8), .CLKS_PER_BIT(Clks), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(2), .SYNC_STAGES(Sync)
  ) dut_p (
    .clk(clk), .reset_b(reset_b), .RX_Data_in(line_p), .RX_Data_Taken(taken_p),
    .RX_Data_out(data_p), .RX_Data_Valid(valid_p), .Parity_Error(perr_p),
    .Framing_Error(ferr_p), .Overrun_Error(ovr_p), .RX_Busy(busy_p)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_n[$];
  exp_t q_p[$];
  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitors: compare every accepted word against the head of its queue.
  logic prev_x_n = 1'b0;
  logic prev_x_p = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_b) begin
      prev_x_n <= 1'b0;
    end else begin
      if (prev_x_n) check("n_valid_one_cycle", 32'(valid_n), 32'd0);
      if (valid_n && taken_n) begin
        if (q_n.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL n_unexpected_word: got %0h required none (t=%0t)", data_n, $time);
        end else begin
          e = q_n.pop_front();
          check("n_data", 32'(data_n), 32'(e.data));
          check("n_parity_err", 32'(perr_n), 32'(e.perr));
          check("n_framing_err", 32'(ferr_n), 32'(e.ferr));
        end
      end
      prev_x_n <= valid_n && taken_n;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_b) begin
      prev_x_p <= 1'b0;
    end else begin
      if (prev_x_p) check("p_valid_one_cycle", 32'(valid_p), 32'd0);
      if (valid_p && taken_p) begin
        if (q_p.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL p_unexpected_word: got %0h required none (t=%0t)", data_p, $time);
        end else begin
          e = q_p.pop_front();
          check("p_data", 32'(data_p), 32'(e.data));
          check("p_parity_err", 32'(perr_p), 32'(e.perr));
          check("p_framing_err", 32'(ferr_p), 32'(e.ferr));
        end
      end
      prev_x_p <= valid_p && taken_p;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit which, input logic b);
    if (which) line_p = b;
    else line_n = b;
  endtask

  task automatic send_bit(input bit which, input logic b);
    set_line(which, b);
    tick(Clks);
  endtask

  // which=0: 8N1 instance; which=1: 8E2 instance (pbit used as the parity bit).
  task automatic send_frame(input bit which, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input bit push);
    exp_t e;
    int nstop;
    nstop  = which ? 2 : 1;
    e.data = data;
    // Even parity: the data bits plus the parity bit must XOR to zero.
    e.perr = which && (((^data) ^ pbit) != 1'b0);
    e.ferr = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) e.ferr = 1'b1;
    if (push) begin
      if (which) q_p.push_back(e);
      else q_n.push_back(e);
    end
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, data[i]);
    if (which) send_bit(which, pbit);
    for (int i = 0; i < nstop; i++) send_bit(which, stops[i]);
    set_line(which, 1'b1);
  endtask

  task automatic wait_drain(input bit which, input string name);
    int n = 0;
    while ((which ? q_p.size() : q_n.size()) != 0 && n < 4 * Clks) begin
      tick(1);
      n++;
    end
    check(name, which ? q_p.size() : q_n.size(), 32'd0);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c3;
    logic [7:0] rdata;
    logic [1:0] rstops;
    logic       rpbit;
    bit         which;

    #1 reset_b = 1'b0;
    line_n = 1'b0;  // line held low across reset release
    tick(5);
    check("rst_n_data", 32'(data_n), 32'd0);
    check("rst_n_valid", 32'(valid_n), 32'd0);
    check("rst_n_perr", 32'(perr_n), 32'd0);
    check("rst_n_ferr", 32'(ferr_n), 32'd0);
    check("rst_n_ovr", 32'(ovr_n), 32'd0);
    check("rst_n_busy", 32'(busy_n), 32'd0);
    check("rst_p_valid", 32'(valid_p), 32'd0);
    check("rst_p_busy", 32'(busy_p), 32'd0);
    reset_b = 1'b1;
    tick(3 * Clks);
    check("low_at_reset_busy", 32'(busy_n), 32'd0);
    check("low_at_reset_valid", 32'(valid_n), 32'd0);
    set_line(0, 1'b1);
    tick(Clks);

    // Basic 8N1 word.
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1);
    wait_drain(0, "a5_drained");
    tick(Clks);
    check("a5_busy_after", 32'(busy_n), 32'd0);
    check("a5_valid_after", 32'(valid_n), 32'd0);
    check("a5_data_held", 32'(data_n), 32'hA5);

    // Short low glitch is rejected.
    set_line(0, 1'b0);
    tick(4);
    set_line(0, 1'b1);
    tick(8 + Sync);
    check("glitch_busy", 32'(busy_n), 32'd0);
    check("glitch_valid", 32'(valid_n), 32'd0);
    tick(Clks);
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1);
    wait_drain(0, "5a_drained");
    tick(Clks);

    // Parity instance: 0x07 with wrong then right even-parity bit.
    send_frame(1, 8'h07, 1'b0, 2'b11, 1);
    wait_drain(1, "par0_drained");
    check("par0_data", 32'(data_p), 32'h07);
    check("par0_perr", 32'(perr_p), 32'd1);
    tick(Clks);
    send_frame(1, 8'h07, 1'b1, 2'b11, 1);
    wait_drain(1, "par1_drained");
    check("par1_perr", 32'(perr_p), 32'd0);
    tick(Clks);

    // Break: 20 bit times low gives exactly one 0x00 framing-error word.
    q_n.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    set_line(0, 1'b0);
    tick(20 * Clks);
    set_line(0, 1'b1);
    tick(4 * Clks);
    check("break_one_word", q_n.size(), 32'd0);
    check("break_busy", 32'(busy_n), 32'd0);
    check("break_ferr", 32'(ferr_n), 32'd1);
    check("break_data", 32'(data_n), 32'h00);

    // Overrun: two back-to-back words with no consumer.
    taken_n = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 1);
    send_frame(0, 8'h22, 1'b0, 2'b11, 0);
    tick(Clks);
    check("ovr_data", 32'(data_n), 32'h11);
    check("ovr_valid", 32'(valid_n), 32'd1);
    check("ovr_flag", 32'(ovr_n), 32'd1);
    check("ovr_pending", q_n.size(), 32'd1);
    taken_n = 1'b1;
    tick(1);
    taken_n = 1'b0;
    tick(1);
    check("ovr_valid_clr", 32'(valid_n), 32'd0);
    check("ovr_flag_clr", 32'(ovr_n), 32'd0);
    check("ovr_popped", q_n.size(), 32'd0);
    tick(Clks);

    // Reset in the middle of data bit 4 of 0xC3, with an older word pending.
    send_frame(0, 8'h96, 1'b0, 2'b11, 0);
    tick(Clks);
    check("pre_rst_valid", 32'(valid_n), 32'd1);
    c3 = 8'hC3;
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, c3[i]);
    set_line(0, c3[4]);
    tick(Clks / 2);
    check("pre_rst_busy", 32'(busy_n), 32'd1);
    reset_b = 1'b0;
    #1;
    check("midrst_data", 32'(data_n), 32'd0);
    check("midrst_valid", 32'(valid_n), 32'd0);
    check("midrst_busy", 32'(busy_n), 32'd0);
    check("midrst_ovr", 32'(ovr_n), 32'd0);
    tick(2);
    reset_b = 1'b1;
    taken_n = 1'b1;
    tick(Clks / 2 - 2);
    for (int i = 5; i < 8; i++) send_bit(0, c3[i]);
    send_bit(0, 1'b1);
    tick(2 * Clks);
    check("post_rst_valid", 32'(valid_n), 32'd0);
    check("post_rst_busy", 32'(busy_n), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1);
    wait_drain(0, "3c_drained");
    check("3c_data", 32'(data_n), 32'h3C);
    tick(Clks);

    // Randomized frames on both instances, with occasional parity/stop errors.
    for (int k = 0; k < 24; k++) begin
      which  = (k % 2) == 1;
      rdata  = 8'($urandom);
      rstops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      rpbit  = ^rdata;
      if (which && $urandom_range(0, 3) == 0) rpbit = ~rpbit;
      send_frame(which, rdata, rpbit, rstops, 1);
      tick($urandom_range(4, 20));
    end
    wait_drain(0, "rand_n_drained");
    wait_drain(1, "rand_p_drained");
    tick(2 * Clks);
    check("rand_n_busy", 32'(busy_n), 32'd0);
    check("rand_p_busy", 32'(busy_p), 32'd0);
    check("rand_n_ovr", 32'(ovr_n), 32'd0);
    check("rand_p_ovr", 32'(ovr_p), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
